// File: rtl/instruction_fetch_if.sv
// Bus between instruction_fetch (master) and its neighbours: PC source, program ROM, decode.
// master = the fetch block, slave = the surrounding environment.
interface instruction_fetch_if #(
   parameter int ADDR_WIDTH  = 7,
   parameter int INSTR_WIDTH = 24
);
   logic [ADDR_WIDTH-1:0]  ProgramCounter;
   logic                   PCHold;
   logic [ADDR_WIDTH-1:0]  RomAddr;
   logic [INSTR_WIDTH-1:0] RomData;
   logic [INSTR_WIDTH-1:0] Instruction;
   logic [ADDR_WIDTH-1:0]  InstrAddr;
   logic                   InstrValid;
   logic                   InstrReady;
   logic                   Flush;

   modport master (
      input  ProgramCounter, RomData, InstrReady, Flush,
      output PCHold, RomAddr, Instruction, InstrAddr, InstrValid
   );

   modport slave (
      output ProgramCounter, RomData, InstrReady, Flush,
      input  PCHold, RomAddr, Instruction, InstrAddr, InstrValid
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetches ROM words at the current PC into a DEPTH-entry FIFO for decode; word valid 2 cycles after issue.
// Credit stall: PCHold rises once buffered + in-flight words reach DEPTH, so the FIFO never overflows.
module instruction_fetch #(
   parameter int ADDR_WIDTH  = 7,
   parameter int INSTR_WIDTH = 24,
   parameter int DEPTH       = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   instruction_fetch_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  addr;
      logic [INSTR_WIDTH-1:0] dat;
   } entry_t;

   entry_t                 mem_q [DEPTH];
   entry_t                 mem_d [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   in_flight_q, in_flight_d;
   logic [ADDR_WIDTH-1:0]  in_flight_addr_q, in_flight_addr_d;
   logic [CNT_W-1:0]       credits_used;
   logic                   pc_hold, issue, push, pop, instr_vld;

   always_comb begin
      // A fetch in flight has already claimed a slot, so it counts against the credit.
      credits_used     = count_q + CNT_W'(in_flight_q);
      pc_hold          = Reset | bus.Flush | (credits_used >= DEPTH_C);
      issue            = ~pc_hold;
      instr_vld        = (count_q != '0);
      push             = in_flight_q & ~bus.Flush;
      pop              = instr_vld & bus.InstrReady & ~bus.Flush;

      in_flight_d      = issue;
      in_flight_addr_d = issue ? bus.ProgramCounter : in_flight_addr_q;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{addr: in_flight_addr_q, dat: bus.RomData};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (bus.Flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
      if (Reset) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         in_flight_q      <= 1'b0;
         in_flight_addr_q <= '0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         in_flight_q      <= in_flight_d;
         in_flight_addr_q <= in_flight_addr_d;
      end
   end

   assign bus.PCHold      = pc_hold;
   assign bus.RomAddr     = bus.ProgramCounter;
   assign bus.InstrValid  = instr_vld;
   assign bus.Instruction = mem_q[rd_ptr_q].dat;
   assign bus.InstrAddr   = mem_q[rd_ptr_q].addr;

   a_no_overflow: assert property (@(posedge Clock) disable iff (Reset)
      !(push && (count_q == DEPTH_C)));
endmodule
